// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit and its fetch queue:
// default reset PC, NOP encoding, PC increment, FSM state encoding, the
// fetch-queue entry layout and a PC alignment helper.
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Width of the outstanding / drop counters. The worst case is FQ_DEPTH
  // squashed requests plus FQ_DEPTH new-stream requests (<= 16 for depth 8).
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous in-order FIFO of {instr, pc} entries.
// Ports:
//   CLK, RESET     clock, asynchronous active-low reset
//   push_i         write push_data_i (accepted when not full, or when popping)
//   push_data_i    entry to write
//   pop_i          drop the head entry (ignored when empty)
//   flush_i        empty the queue; overrides push and pop
//   head_o         head entry (undefined contents when empty_o=1)
//   full_o         count_o == DEPTH
//   empty_o        count_o == 0
//   count_o        current occupancy
// ---------------------------------------------------------------------------
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push_i,
  input  fq_entry_t     push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fq_entry_t     head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full queue can still accept a push in the same cycle as a pop.
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; an entry is only observable after
  // it was written, because count_q gates validity.
  always_ff @(posedge CLK) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Front-end fetch stage. Owns the fetch PC, issues word reads over a
// req/gnt/ack handshake, buffers returned words in an in-order fetch queue
// and presents the head to the IF/ID register. Redirects squash the stream;
// acks for requests issued before a redirect are counted off and discarded.
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset
//   STALL               head must not be consumed this cycle
//   Redirect            restart fetching at Redirect_PC (bits [1:0] ignored)
//   Mem_Req/Mem_Addr    read request and word-aligned address
//   Mem_Gnt             request accepted this cycle
//   Mem_Ack/Mem_Data    in-order read response
//   Instr1_IF           head instruction (0 when invalid)
//   Instr_PC_IF         head PC (0 when invalid)
//   Instr_PC_Plus4_IF   head PC + 4 (0 when invalid)
//   Instr_Valid         head entry valid
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Gnt,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Data,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Instr_Valid
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  fq_entry_t         fq_head, fq_push_data;
  logic              fq_full, fq_empty, fq_push, fq_pop;
  logic [CW-1:0]     fq_count;

  logic [CNT_W-1:0]  credit_used;
  logic              accept, ack_drop, ack_keep;

  // Entries already queued plus requests whose data will be kept; squashed
  // requests do not consume queue space.
  assign credit_used = {{(CNT_W-CW){1'b0}}, fq_count} + (outstanding_q - drop_cnt_q);

  assign Mem_Req  = (state_q != BOOT) && !Redirect && (credit_used < CNT_W'(FQ_DEPTH));
  assign Mem_Addr = fetch_pc_q;
  assign accept   = Mem_Req & Mem_Gnt;

  // An ack in the redirect cycle always belongs to the old stream.
  assign ack_drop = Mem_Ack & (drop_cnt_q != '0);
  assign ack_keep = Mem_Ack & (drop_cnt_q == '0) & !Redirect;

  assign fq_push      = ack_keep;
  assign fq_push_data = '{instr: Mem_Data, pc: resp_pc_q};
  assign fq_pop       = !fq_empty && !STALL && !Redirect;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (fq_push),
    .push_data_i (fq_push_data),
    .pop_i       (fq_pop),
    .flush_i     (Redirect),
    .head_o      (fq_head),
    .full_o      (fq_full),
    .empty_o     (fq_empty),
    .count_o     (fq_count)
  );

  assign Instr_Valid       = !fq_empty;
  assign Instr1_IF         = Instr_Valid ? fq_head.instr       : INSTR_NOP;
  assign Instr_PC_IF       = Instr_Valid ? fq_head.pc          : '0;
  assign Instr_PC_Plus4_IF = Instr_Valid ? fq_head.pc + PC_STEP : '0;

  // NOTE: every signal driven here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(Mem_Ack);

    if (Redirect) begin
      // No request issues this cycle, so everything still in flight is old.
      drop_cnt_d = outstanding_q - CNT_W'(Mem_Ack);
      fetch_pc_d = align_pc(Redirect_PC);
      resp_pc_d  = align_pc(Redirect_PC);
      state_d    = (drop_cnt_d != '0) ? FLUSH : RUN;
    end else begin
      if (accept)   fetch_pc_d = fetch_pc_q + PC_STEP;
      if (ack_drop) drop_cnt_d = drop_cnt_q - 1'b1;
      if (ack_keep) resp_pc_d  = resp_pc_q + PC_STEP;
      unique case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Credit accounting keeps a kept ack from ever meeting a full queue.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET)
    !(ack_keep && fq_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit: a cycle table for reset/stall,
// directed redirect/wrap/reset sequences, and a randomized run compared
// against a transaction-level model (request list with keep flags, queue of
// fetched entries) and a memory responder with random grant and latency.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = '0;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Gnt = 1'b0;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_Data = '0;
  logic [31:0] Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;
  logic        Instr_Valid;

  instr_fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .Redirect          (Redirect),
    .Redirect_PC       (Redirect_PC),
    .Mem_Req           (Mem_Req),
    .Mem_Addr          (Mem_Addr),
    .Mem_Gnt           (Mem_Gnt),
    .Mem_Ack           (Mem_Ack),
    .Mem_Data          (Mem_Data),
    .Instr1_IF         (Instr1_IF),
    .Instr_PC_IF       (Instr_PC_IF),
    .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
    .Instr_Valid       (Instr_Valid)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  // Reference model state
  typedef struct { logic [31:0] addr; bit keep; } out_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  out_t        m_out[$];
  ent_t        m_fq[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  bit          m_booted;

  typedef struct {
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[12];

  // Word 0x00400000 holds 0xA0, the next word 0xA1, and so on.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'hFFF0_00A0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int kept_out();
    int n = 0;
    foreach (m_out[i]) if (m_out[i].keep) n++;
    return n;
  endfunction

  function automatic bit model_req();
    return m_booted && !Redirect && ((m_fq.size() + kept_out()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_booted = 1'b0;
    m_out.delete();
    m_fq.delete();
    mem_q.delete();
  endtask

  task automatic drive(input bit stall, input bit redir, input logic [31:0] rpc);
    STALL = stall;
    Redirect = redir;
    Redirect_PC = rpc;
    Mem_Gnt = ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      Mem_Ack = 1'b1;
      Mem_Data = mem_word(mem_q[0].addr);
    end else begin
      Mem_Ack = 1'b0;
      Mem_Data = $urandom;
    end
    #1;
  endtask

  task automatic model_check();
    check("req", {31'b0, Mem_Req}, {31'b0, model_req()});
    check("addr", Mem_Addr, m_pc);
    if (m_fq.size() > 0) begin
      check("valid", {31'b0, Instr_Valid}, 32'd1);
      check("instr", Instr1_IF, m_fq[0].instr);
      check("pc", Instr_PC_IF, m_fq[0].pc);
      check("pc4", Instr_PC_Plus4_IF, m_fq[0].pc + 32'd4);
    end else begin
      check("valid", {31'b0, Instr_Valid}, 32'd0);
      check("instr", Instr1_IF, 32'd0);
      check("pc", Instr_PC_IF, 32'd0);
      check("pc4", Instr_PC_Plus4_IF, 32'd0);
    end
  endtask

  // Apply the clock edge to the model and the memory, then wait for the
  // next sampling point.
  task automatic advance();
    bit   exp_req;
    out_t o;
    ent_t e;
    exp_req = model_req();
    if (m_fq.size() > 0 && !STALL && !Redirect) void'(m_fq.pop_front());
    if (Mem_Ack && m_out.size() > 0) begin
      o = m_out.pop_front();
      if (o.keep && !Redirect) begin
        e.instr = mem_word(o.addr);
        e.pc = o.addr;
        m_fq.push_back(e);
      end
    end
    if (Redirect) begin
      m_fq.delete();
      foreach (m_out[i]) m_out[i].keep = 1'b0;
      m_pc = {Redirect_PC[31:2], 2'b00};
    end else if (exp_req && Mem_Gnt) begin
      o.addr = m_pc;
      o.keep = 1'b1;
      m_out.push_back(o);
      m_pc = m_pc + 32'd4;
    end
    if (Mem_Ack) void'(mem_q.pop_front());
    if (Mem_Req && Mem_Gnt) begin
      mreq_t r;
      r.addr = Mem_Addr;
      r.due = cyc + int'($urandom_range(lat_max, lat_min));
      mem_q.push_back(r);
    end
    m_booted = 1'b1;
    cyc++;
    @(negedge CLK);
  endtask

  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
    drive(stall, redir, rpc);
    model_check();
    advance();
  endtask

  // Entered at a falling edge; returns at a falling edge with reset released,
  // so the next step() is the BOOT cycle.
  task automatic reset_dut();
    RESET = 1'b0;
    STALL = 1'b0;
    Redirect = 1'b0;
    Mem_Gnt = 1'b0;
    Mem_Ack = 1'b0;
    #1;
    check("rst_req", {31'b0, Mem_Req}, 32'd0);
    check("rst_addr", Mem_Addr, RST_PC);
    check("rst_valid", {31'b0, Instr_Valid}, 32'd0);
    check("rst_instr", Instr1_IF, 32'd0);
    check("rst_pc", Instr_PC_IF, 32'd0);
    check("rst_pc4", Instr_PC_Plus4_IF, 32'd0);
    model_reset();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!Instr_Valid && n < 20) begin
      step(1'b0, 1'b0, 32'd0);
      n++;
    end
    check(name, {31'b0, Instr_Valid}, 32'd1);
  endtask

  task automatic set_row(input int i, input bit stall, input bit req, input logic [31:0] addr,
                         input bit valid, input logic [31:0] instr, input logic [31:0] pc);
    tbl[i].stall = stall;
    tbl[i].req = req;
    tbl[i].addr = addr;
    tbl[i].valid = valid;
    tbl[i].instr = instr;
    tbl[i].pc = pc;
  endtask

  initial begin
    // Reset release, always-grant, 1-cycle ack; stall 5 cycles from head=0xA0.
    set_row(0,  0, 0, 32'h0040_0000, 0, 32'h0,  32'h0);
    set_row(1,  0, 1, 32'h0040_0000, 0, 32'h0,  32'h0);
    set_row(2,  0, 1, 32'h0040_0004, 0, 32'h0,  32'h0);
    set_row(3,  1, 0, 32'h0040_0008, 1, 32'hA0, 32'h0040_0000);
    set_row(4,  1, 0, 32'h0040_0008, 1, 32'hA0, 32'h0040_0000);
    set_row(5,  1, 0, 32'h0040_0008, 1, 32'hA0, 32'h0040_0000);
    set_row(6,  1, 0, 32'h0040_0008, 1, 32'hA0, 32'h0040_0000);
    set_row(7,  1, 0, 32'h0040_0008, 1, 32'hA0, 32'h0040_0000);
    set_row(8,  0, 0, 32'h0040_0008, 1, 32'hA0, 32'h0040_0000);
    set_row(9,  0, 1, 32'h0040_0008, 1, 32'hA1, 32'h0040_0004);
    set_row(10, 0, 1, 32'h0040_000C, 0, 32'h0,  32'h0);
    set_row(11, 0, 0, 32'h0040_0010, 1, 32'hA2, 32'h0040_0008);

    @(negedge CLK);
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].stall, 1'b0, 32'd0);
      check($sformatf("tbl%0d_req", i), {31'b0, Mem_Req}, {31'b0, tbl[i].req});
      check($sformatf("tbl%0d_addr", i), Mem_Addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, Instr_Valid}, {31'b0, tbl[i].valid});
      check($sformatf("tbl%0d_instr", i), Instr1_IF, tbl[i].instr);
      check($sformatf("tbl%0d_pc", i), Instr_PC_IF, tbl[i].pc);
      check($sformatf("tbl%0d_pc4", i), Instr_PC_Plus4_IF,
            tbl[i].valid ? tbl[i].pc + 32'd4 : 32'd0);
      model_check();
      advance();
    end

    // Redirect with two requests outstanding (3-cycle ack latency).
    reset_dut();
    lat_min = 3; lat_max = 3;
    repeat (3) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0040_0103);
    check("s3_addr", Mem_Addr, 32'h0040_0100);
    wait_valid("s3_wait_valid");
    check("s3_pc", Instr_PC_IF, 32'h0040_0100);
    check("s3_instr", Instr1_IF, mem_word(32'h0040_0100));
    repeat (6) step(1'b0, 1'b0, 32'd0);

    // Redirect in the same cycle as an ack, with STALL high.
    reset_dut();
    lat_min = 1; lat_max = 1;
    repeat (3) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0040_0200);
    check("s4_valid", {31'b0, Instr_Valid}, 32'd0);
    check("s4_addr", Mem_Addr, 32'h0040_0200);
    repeat (5) step(1'b0, 1'b0, 32'd0);

    // Redirect to the top of the address space: the PC wraps to 0.
    reset_dut();
    repeat (3) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    check("s5_addr", Mem_Addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0);
    check("s5_wrap_addr", Mem_Addr, 32'h0000_0000);
    wait_valid("s5_wait_valid");
    check("s5_pc", Instr_PC_IF, 32'hFFFF_FFFC);
    check("s5_pc4", Instr_PC_Plus4_IF, 32'h0000_0000);
    check("s5_instr", Instr1_IF, mem_word(32'hFFFF_FFFC));
    step(1'b0, 1'b0, 32'd0);
    wait_valid("s5_wait_valid2");
    check("s5_pc_wrapped", Instr_PC_IF, 32'h0000_0000);
    repeat (4) step(1'b0, 1'b0, 32'd0);

    // Reset asserted with a request pending and one outstanding.
    reset_dut();
    repeat (2) step(1'b0, 1'b0, 32'd0);
    STALL = 1'b0; Redirect = 1'b0; Mem_Gnt = 1'b0; Mem_Ack = 1'b0;
    #1;
    check("pre_rst_req", {31'b0, Mem_Req}, 32'd1);
    reset_dut();
    step(1'b0, 1'b0, 32'd0);
    check("resume_addr", Mem_Addr, RST_PC);
    drive(1'b0, 1'b0, 32'd0);
    check("resume_req", {31'b0, Mem_Req}, 32'd1);
    model_check();
    advance();
    repeat (6) step(1'b0, 1'b0, 32'd0);

    // Randomized traffic against the model.
    reset_dut();
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      bit          st, rd;
      logic [31:0] rpc;
      st = ($urandom_range(99) < 30);
      rd = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      else                        rpc = $urandom;
      step(st, rd, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
